// File: rtl/regs_file_if.sv
// Execute-stage write port and decode-stage read ports of the RV32I integer register file.
// The register file takes the slave modport; the pipeline side drives the master modport.
interface regs_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              rd_wen_i;
  logic [ADDR_W-1:0] reg1_raddr_i;
  logic [ADDR_W-1:0] reg2_raddr_i;
  logic [DATA_W-1:0] reg1_rdata_o;
  logic [DATA_W-1:0] reg2_rdata_o;

  modport master (
    output rd_addr_i, rd_data_i, rd_wen_i, reg1_raddr_i, reg2_raddr_i,
    input  reg1_rdata_o, reg2_rdata_o
  );

  modport slave (
    input  rd_addr_i, rd_data_i, rd_wen_i, reg1_raddr_i, reg2_raddr_i,
    output reg1_rdata_o, reg2_rdata_o
  );
endinterface

// File: rtl/regs_file.sv
// RV32I integer register file: x0 hardwired to zero, two async read ports, one sync write port.
// Define REGS_WRITE_BYPASS_EN to return same-cycle write data on a matching read (write-through).
module regs_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  regs_file_if.slave  bus
);

  // x0 has no storage at all; its reads are forced to zero below.
  logic [DATA_W-1:0] regs_q [1:REG_NUM-1];

  logic              wr_hit;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign wr_hit = bus.rd_wen_i && (bus.rd_addr_i != '0);

  // NOTE: this array is reset on purpose (cleared architectural state after reset), which
  // rules out RAM-macro mapping; only do this for small flop-based arrays like this one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      // NOTE: non-blocking so every reader in this edge sees the pre-edge value.
      regs_q[bus.rd_addr_i] <= bus.rd_data_i;
    end
  end

  assign raddr[0] = bus.reg1_raddr_i;
  assign raddr[1] = bus.reg2_raddr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: default first so no path through this block can infer a latch.
      rdata[p] = '0;
      if (rst_n && (raddr[p] != '0)) begin
        rdata[p] = regs_q[raddr[p]];
`ifdef REGS_WRITE_BYPASS_EN
        if (wr_hit && (raddr[p] == bus.rd_addr_i)) begin
          rdata[p] = bus.rd_data_i;
        end
`endif
      end
    end
  end

  assign bus.reg1_rdata_o = rdata[0];
  assign bus.reg2_rdata_o = rdata[1];

endmodule
